sample_writer: RTL and testbench

SAMPLE_WRITER -- requirements
Module: sample_writer

---
 rtl/sample_writer.sv | 82 ++++++++
 tb/tb_sample_writer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_writer.sv
// Sample writer: accepts N_SAMPLES (x,y) pairs per frame and writes each one
// to the sample memory at consecutive addresses. It pulses end_w on the last write.
module sample_writer #(
    parameter int N_SAMPLES = 150,
    parameter int DW        = 20,
    parameter int AW        = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start_w,
    input  logic          in_valid,
    input  logic [DW-1:0] x_in,
    input  logic [DW-1:0] y_in,
    output logic          in_ready,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] x_out,
    output logic [DW-1:0] y_out,
    output logic          busy,
    output logic          end_w
);

    // state   | meaning
    // S_IDLE  | waiting for start_w
    // S_INIT  | one cycle, clears the sample counter
    // S_WRITE | accepting pairs, one memory write per handshake
    // S_DONE  | one cycle, final pair written, end_w pulsed
    typedef enum logic [1:0] {S_IDLE, S_INIT, S_WRITE, S_DONE} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] count;
    logic          handshake;
    logic          last_pair;

    assign handshake = in_valid & in_ready;
    assign last_pair = (count == AW'(N_SAMPLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_w) state_nxt = S_INIT;
            S_INIT:  state_nxt = S_WRITE;
            S_WRITE: if (handshake && last_pair) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == S_WRITE);
        busy     = (state != S_IDLE);
        end_w    = (state == S_DONE);
    end

    // The counter holds at N_SAMPLES-1 after the last pair, so it cannot wrap
    // even when N_SAMPLES == 2**AW; S_INIT clears it for the next frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count   <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            x_out   <= '0;
            y_out   <= '0;
        end else begin
            wr_en <= handshake;
            if (state == S_INIT) begin
                count <= '0;
            end else if (handshake) begin
                wr_addr <= count;
                x_out   <= x_in;
                y_out   <= y_in;
                if (!last_pair) count <= count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sample_writer.sv
// Scoreboard bench for sample_writer: a 150-sample instance and a 4-sample
// instance share one stimulus stream and are checked against frame-level models.
module tb_sample_writer;

    localparam int DW  = 20;
    localparam int AW  = 8;
    localparam int NS0 = 150;
    localparam int NS1 = 4;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] x;
        logic [DW-1:0] y;
        logic          last;
    } exp_t;

    logic          clk;
    logic          reset;
    logic          start_w;
    logic          in_valid;
    logic [DW-1:0] x_in;
    logic [DW-1:0] y_in;

    logic          in_ready_a [2];
    logic          wr_en_a    [2];
    logic [AW-1:0] wr_addr_a  [2];
    logic [DW-1:0] x_out_a    [2];
    logic [DW-1:0] y_out_a    [2];
    logic          busy_a     [2];
    logic          end_w_a    [2];

    // Frame model per instance: phase 0 idle, 1 init, 2 accepting, 3 done
    int            m_phase [2];
    int            m_cnt   [2];
    logic [AW-1:0] last_addr [2];
    logic [DW-1:0] last_x    [2];
    logic [DW-1:0] last_y    [2];
    exp_t          q0[$];
    exp_t          q1[$];

    int checks;
    int failures;

    sample_writer #(.N_SAMPLES(NS0), .DW(DW), .AW(AW)) dut0 (
        .clk(clk), .reset(reset), .start_w(start_w), .in_valid(in_valid),
        .x_in(x_in), .y_in(y_in), .in_ready(in_ready_a[0]), .wr_en(wr_en_a[0]),
        .wr_addr(wr_addr_a[0]), .x_out(x_out_a[0]), .y_out(y_out_a[0]),
        .busy(busy_a[0]), .end_w(end_w_a[0])
    );

    sample_writer #(.N_SAMPLES(NS1), .DW(DW), .AW(AW)) dut1 (
        .clk(clk), .reset(reset), .start_w(start_w), .in_valid(in_valid),
        .x_in(x_in), .y_in(y_in), .in_ready(in_ready_a[1]), .wr_en(wr_en_a[1]),
        .wr_addr(wr_addr_a[1]), .x_out(x_out_a[1]), .y_out(y_out_a[1]),
        .busy(busy_a[1]), .end_w(end_w_a[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string name, int d, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s dut%0d actual=%0h required=%0h t=%0t", name, d, act, req, $time);
        end
    endfunction

    function automatic int ns(int d);
        return (d == 0) ? NS0 : NS1;
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            m_phase[d]   = 0;
            m_cnt[d]     = 0;
            last_addr[d] = '0;
            last_x[d]    = '0;
            last_y[d]    = '0;
        end
        q0.delete();
        q1.delete();
    endfunction

    // Advance one instance's frame model across a clock edge using pre-edge inputs.
    function automatic void model_edge(int d);
        exp_t e;
        case (m_phase[d])
            0: if (start_w) m_phase[d] = 1;
            1: begin
                m_cnt[d]   = 0;
                m_phase[d] = 2;
            end
            2: if (in_valid) begin
                e.addr = AW'(m_cnt[d]);
                e.x    = x_in;
                e.y    = y_in;
                e.last = (m_cnt[d] == ns(d) - 1);
                if (d == 0) q0.push_back(e);
                else        q1.push_back(e);
                if (e.last) m_phase[d] = 3;
                else        m_cnt[d]++;
            end
            default: m_phase[d] = 0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        if (reset) begin
            model_edge(0);
            model_edge(1);
        end
        #1;
    endtask

    task automatic chk_zero(string name);
        for (int d = 0; d < 2; d++) begin
            chk({name, "_in_ready"}, d, 32'(in_ready_a[d]), 0);
            chk({name, "_wr_en"},    d, 32'(wr_en_a[d]),    0);
            chk({name, "_end_w"},    d, 32'(end_w_a[d]),    0);
            chk({name, "_busy"},     d, 32'(busy_a[d]),     0);
            chk({name, "_wr_addr"},  d, 32'(wr_addr_a[d]),  0);
            chk({name, "_x_out"},    d, 32'(x_out_a[d]),    0);
            chk({name, "_y_out"},    d, 32'(y_out_a[d]),    0);
        end
    endtask

    task automatic wait_idle(string name, int budget);
        int n = 0;
        while ((m_phase[0] != 0 || m_phase[1] != 0) && n < budget) begin
            x_in = DW'($urandom);
            y_in = DW'($urandom);
            step();
            n++;
        end
        if (n >= budget) chk({name, "_timeout"}, 0, 1, 0);
    endtask

    // Monitor: compare every DUT write against the scoreboard queue
    function automatic void check_dut(int d);
        exp_t e;
        chk("in_ready", d, 32'(in_ready_a[d]), 32'(m_phase[d] == 2));
        chk("busy",     d, 32'(busy_a[d]),     32'(m_phase[d] != 0));
        if (wr_en_a[d]) begin
            if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                chk("unexpected_write", d, 32'(wr_addr_a[d]), 32'hFFFF_FFFF);
            end else begin
                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                chk("wr_addr", d, 32'(wr_addr_a[d]), 32'(e.addr));
                chk("x_out",   d, 32'(x_out_a[d]),   32'(e.x));
                chk("y_out",   d, 32'(y_out_a[d]),   32'(e.y));
                chk("end_w",   d, 32'(end_w_a[d]),   32'(e.last));
                last_addr[d] = e.addr;
                last_x[d]    = e.x;
                last_y[d]    = e.y;
            end
        end else begin
            chk("end_w_idle",   d, 32'(end_w_a[d]),   0);
            chk("wr_addr_hold", d, 32'(wr_addr_a[d]), 32'(last_addr[d]));
            chk("x_out_hold",   d, 32'(x_out_a[d]),   32'(last_x[d]));
            chk("y_out_hold",   d, 32'(y_out_a[d]),   32'(last_y[d]));
        end
    endfunction

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) check_dut(d);
    end

    initial begin
        checks   = 0;
        failures = 0;
        model_reset();
        reset    = 1'b0;
        start_w  = 1'b0;
        in_valid = 1'b0;
        x_in     = '0;
        y_in     = '0;
        #2;
        chk_zero("por");
        @(posedge clk);
        #2;
        reset = 1'b1;

        // Spurious in_valid while idle, then a back-to-back frame with x=k, y=2k
        in_valid = 1'b1;
        repeat (3) step();
        start_w = 1'b1;
        step();
        start_w = 1'b0;
        begin
            int n = 0;
            while ((m_phase[0] != 0 || m_phase[1] != 0) && n < 400) begin
                x_in = DW'(m_cnt[0]);
                y_in = DW'(2 * m_cnt[0]);
                step();
                n++;
            end
            if (n >= 400) chk("frameA_timeout", 0, 1, 0);
        end
        repeat (2) step();

        // Gapped input 1,0,0,1 with a spurious start_w at sample 40
        start_w = 1'b1;
        step();
        start_w = 1'b0;
        begin
            int n = 0;
            bit pulsed = 0;
            while (m_phase[0] != 0 && n < 1000) begin
                in_valid = (n % 4 == 0) || (n % 4 == 3);
                x_in     = DW'($urandom);
                y_in     = DW'($urandom);
                start_w  = (!pulsed && m_phase[0] == 2 && m_cnt[0] == 40);
                if (start_w) pulsed = 1;
                step();
                n++;
            end
            start_w = 1'b0;
            if (n >= 1000) chk("frameB_timeout", 0, 1, 0);
        end
        in_valid = 1'b0;
        wait_idle("frameB_tail", 50);
        step();

        // Reset in the middle of a frame at sample 75
        in_valid = 1'b1;
        start_w  = 1'b1;
        step();
        start_w = 1'b0;
        begin
            int n = 0;
            while (!(m_phase[0] == 2 && m_cnt[0] == 75) && n < 300) begin
                x_in = DW'($urandom);
                y_in = DW'($urandom);
                step();
                n++;
            end
            if (n >= 300) chk("frameR_timeout", 0, 1, 0);
        end
        reset = 1'b0;
        #1;
        chk_zero("midreset");
        model_reset();
        repeat (2) step();
        reset = 1'b1;
        repeat (3) step();

        // Fresh frame after reset with random valid pattern
        start_w = 1'b1;
        step();
        start_w = 1'b0;
        begin
            int n = 0;
            while ((m_phase[0] != 0 || m_phase[1] != 0) && n < 1500) begin
                in_valid = 1'($urandom_range(0, 1));
                x_in     = DW'($urandom);
                y_in     = DW'($urandom);
                step();
                n++;
            end
            if (n >= 1500) chk("frameC_timeout", 0, 1, 0);
        end
        step();

        // start_w held high: the 4-sample instance runs repeated frames
        start_w  = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            x_in = DW'($urandom);
            y_in = DW'($urandom);
            step();
        end
        start_w = 1'b0;
        wait_idle("frameD", 400);
        in_valid = 1'b0;
        repeat (3) step();

        chk("q0_drained", 0, 32'(q0.size()), 0);
        chk("q1_drained", 1, 32'(q1.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
